// File: rtl/pipe_enable_seq.sv
// Enable sequencer for N chained serial-link stages: ramps stage enables up from stage 0, holds, then drains upstream-first.
// Optional build macro PIPE_SEQ_AUTO_RUN_EN: an implicit start with DEFAULT_GAP on the first edge after reset release.
module pipe_enable_seq #(
    parameter int NUM_STAGES  = 4,
    parameter int GAP_W       = 4,
    parameter int DEFAULT_GAP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [GAP_W-1:0]      gap,
    output logic [NUM_STAGES-1:0] en,
    output logic                  busy,
    output logic                  run,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [NUM_STAGES-1:0] en_next;
    logic [GAP_W-1:0]      cnt, cnt_next;
    logic [GAP_W-1:0]      gap_q, gap_next;
    logic                  done_next;
    logic                  start_eff;
    logic [GAP_W-1:0]      gap_eff;
    logic [NUM_STAGES-1:0] en_drop;

`ifdef PIPE_SEQ_AUTO_RUN_EN
    logic auto_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) auto_pend <= 1'b1;
        else      auto_pend <= 1'b0;
    end

    assign start_eff = start | auto_pend;
    assign gap_eff   = auto_pend ? GAP_W'(DEFAULT_GAP) : gap;
`else
    assign start_eff = start;
    assign gap_eff   = gap;
`endif

    // Enables are a contiguous run of ones, so clearing the lowest set bit drops the most upstream running stage.
    assign en_drop = en & (en - NUM_STAGES'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        en_next    = en;
        cnt_next   = cnt;
        gap_next   = gap_q;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_eff && !stop) begin
                    en_next    = NUM_STAGES'(1);
                    cnt_next   = gap_eff;
                    gap_next   = gap_eff;
                    state_next = RAMP_UP;
                end
            end
            RAMP_UP, RUN: begin
                if (stop) begin
                    en_next  = en_drop;
                    cnt_next = gap_q;
                    if (en_drop == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RAMP_DOWN;
                    end
                end else if (state == RAMP_UP) begin
                    if (cnt != '0) begin
                        cnt_next = cnt - GAP_W'(1);
                    end else begin
                        en_next  = {en[NUM_STAGES-2:0], 1'b1};
                        cnt_next = gap_q;
                        if (&en[NUM_STAGES-2:0]) state_next = RUN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (cnt != '0) begin
                    cnt_next = cnt - GAP_W'(1);
                end else begin
                    en_next  = en_drop;
                    cnt_next = gap_q;
                    if (en_drop == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // busy/run are flopped from the next state so every output changes on the same edge as en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            en    <= '0;
            cnt   <= '0;
            gap_q <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            run   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state <= state_next;
            en    <= en_next;
            cnt   <= cnt_next;
            gap_q <= gap_next;
            done  <= done_next;
            busy  <= (state_next != IDLE);
            run   <= (state_next == RUN);
        end
    end

endmodule
